// File: rtl/ctrl_fsm.sv
// ctrl_fsm -- multi-cycle processor control state machine.
//
// Sequences FETCH -> DECODE -> EXEC -> (MEM) -> (WB) -> FETCH, and parks
// in HALT on opcodes 110/111 until reset.
//
// Ports:
//   clk        system clock, all state changes on the rising edge
//   rst        asynchronous active-high reset
//   opcode     decoded opcode, sampled in DECODE only
//   func       decoded function field, sampled in DECODE only
//   br_cond    branch condition, used in EXEC for opcode 011
//   mem_ready  memory completes the current request this cycle
//   ir_we, pc_we, reg_we, alu_src, mem_req, mem_wr, link, halt
//              control strobes (1 bit each)
//   pc_src     00 PC+1, 01 branch target, 10 jump target
//   state      current state (FETCH=0 .. HALT=5)
//
// Optional build macro CTRL_PERF_CNT_EN adds two free-running counters:
//   retired    instructions completed (entries into FETCH from EXEC/MEM/WB)
//   stall_cyc  FETCH/MEM cycles spent waiting for mem_ready
module ctrl_fsm (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  opcode,
  input  logic [3:0]  func,
  input  logic        br_cond,
  input  logic        mem_ready,
  output logic        ir_we,
  output logic        pc_we,
  output logic        reg_we,
  output logic        alu_src,
  output logic        mem_req,
  output logic        mem_wr,
  output logic        link,
  output logic        halt,
  output logic [1:0]  pc_src,
  output logic [2:0]  state
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [31:0] retired,
  output logic [31:0] stall_cyc
`endif
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [2:0] OP_ALU  = 3'b000;
  localparam logic [2:0] OP_IMM  = 3'b001;
  localparam logic [2:0] OP_LS   = 3'b010;
  localparam logic [2:0] OP_BR   = 3'b011;
  localparam logic [2:0] OP_JMP  = 3'b100;
  localparam logic [2:0] OP_CALL = 3'b101;

  state_t     state_reg;
  logic [2:0] op_reg;
  logic [3:0] func_reg;

  // Opcode 101 with func[1:0]==01 is a call (jump + link write-back);
  // any other func is a plain jump/return.
  logic is_call;
  assign is_call = (op_reg == OP_CALL) && (func_reg[1:0] == 2'b01);

  // Only func[1:0] steer the control flow; the upper bits are latched
  // for completeness but have no effect here.
  logic func_hi_unused;
  assign func_hi_unused = ^func_reg[3:2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_FETCH;
      op_reg    <= 3'b000;
      func_reg  <= 4'b0000;
    end else begin
      case (state_reg)
        S_FETCH: begin
          if (mem_ready) state_reg <= S_DECODE;
        end
        S_DECODE: begin
          op_reg    <= opcode;
          func_reg  <= func;
          state_reg <= (opcode[2:1] == 2'b11) ? S_HALT : S_EXEC;
        end
        S_EXEC: begin
          case (op_reg)
            OP_ALU, OP_IMM: state_reg <= S_WB;
            OP_LS:          state_reg <= S_MEM;
            OP_CALL:        state_reg <= is_call ? S_WB : S_FETCH;
            default:        state_reg <= S_FETCH;
          endcase
        end
        S_MEM: begin
          // func[0]=1 is a store: nothing to write back.
          if (mem_ready) state_reg <= func_reg[0] ? S_FETCH : S_WB;
        end
        S_WB:    state_reg <= S_FETCH;
        S_HALT:  state_reg <= S_HALT;
        default: state_reg <= S_FETCH;
      endcase
    end
  end

  assign state = state_reg;

  // Strobes are decoded from the state and the latched instruction. The
  // FETCH/MEM handshake and the branch decision are qualified in the same
  // cycle by mem_ready and br_cond. Everything is held quiet while rst is
  // asserted so an aborted instruction issues no write.
  always_comb begin
    ir_we   = 1'b0;
    pc_we   = 1'b0;
    reg_we  = 1'b0;
    alu_src = 1'b0;
    mem_req = 1'b0;
    mem_wr  = 1'b0;
    link    = 1'b0;
    halt    = 1'b0;
    pc_src  = 2'b00;
    if (!rst) begin
      case (state_reg)
        S_FETCH: begin
          mem_req = 1'b1;
          ir_we   = mem_ready;
          pc_we   = mem_ready;
        end
        S_EXEC: begin
          case (op_reg)
            OP_IMM, OP_LS: alu_src = 1'b1;
            OP_BR: begin
              pc_we  = br_cond;
              pc_src = br_cond ? 2'b01 : 2'b00;
            end
            OP_JMP, OP_CALL: begin
              pc_we  = 1'b1;
              pc_src = 2'b10;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          mem_req = 1'b1;
          mem_wr  = func_reg[0];
        end
        S_WB: begin
          reg_we = 1'b1;
          link   = is_call;
        end
        S_HALT:  halt = 1'b1;
        default: ;
      endcase
    end
  end

`ifdef CTRL_PERF_CNT_EN
  // An instruction retires on the edge that takes EXEC/MEM/WB back to FETCH.
  logic retire;
  always_comb begin
    retire = 1'b0;
    case (state_reg)
      S_EXEC:  retire = !((op_reg == OP_ALU) || (op_reg == OP_IMM) ||
                          (op_reg == OP_LS) || is_call);
      S_MEM:   retire = mem_ready && func_reg[0];
      S_WB:    retire = 1'b1;
      default: retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired   <= 32'd0;
      stall_cyc <= 32'd0;
    end else begin
      if (retire) retired <= retired + 32'd1;
      if (((state_reg == S_FETCH) || (state_reg == S_MEM)) && !mem_ready)
        stall_cyc <= stall_cyc + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ctrl_fsm.sv
// tb_ctrl_fsm -- self-checking bench for ctrl_fsm.
// A per-cycle vector table (inputs + expected state/strobes) covers every
// opcode path, stalls and reset-from-HALT; hand-written sequences cover the
// long HALT dwell and asynchronous reset during a store's MEM wait.
// Build with CTRL_PERF_CNT_EN defined to also check the counters.
module tb_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  opcode = 3'd0;
  logic [3:0]  func = 4'd0;
  logic        br_cond = 1'b0;
  logic        mem_ready = 1'b0;
  logic        ir_we, pc_we, reg_we, alu_src, mem_req, mem_wr, link, halt;
  logic [1:0]  pc_src;
  logic [2:0]  state;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] retired, stall_cyc;
`endif

  ctrl_fsm dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func(func),
    .br_cond(br_cond), .mem_ready(mem_ready),
    .ir_we(ir_we), .pc_we(pc_we), .reg_we(reg_we), .alu_src(alu_src),
    .mem_req(mem_req), .mem_wr(mem_wr), .link(link), .halt(halt),
    .pc_src(pc_src), .state(state)
`ifdef CTRL_PERF_CNT_EN
    , .retired(retired), .stall_cyc(stall_cyc)
`endif
  );

  always #5 clk = ~clk;

  // Strobe vector: {ir_we,pc_we,reg_we,alu_src,mem_req,mem_wr,link,halt,pc_src}
  localparam logic [9:0] O_Z   = 10'b0000000000;
  localparam logic [9:0] O_F   = 10'b0000100000; // FETCH waiting
  localparam logic [9:0] O_FR  = 10'b1100100000; // FETCH with mem_ready
  localparam logic [9:0] O_IMM = 10'b0001000000; // EXEC imm / load-store
  localparam logic [9:0] O_BR  = 10'b0100000001; // EXEC branch taken
  localparam logic [9:0] O_J   = 10'b0100000010; // EXEC jump/call/return
  localparam logic [9:0] O_MLD = 10'b0000100000; // MEM load
  localparam logic [9:0] O_MST = 10'b0000110000; // MEM store
  localparam logic [9:0] O_WB  = 10'b0010000000; // WB
  localparam logic [9:0] O_WBL = 10'b0010001000; // WB with link
  localparam logic [9:0] O_H   = 10'b0000000100; // HALT

  typedef struct {
    logic       r;
    logic [2:0] op;
    logic [3:0] fn;
    logic       br;
    logic       mr;
    logic [2:0] st;
    logic [9:0] o;
  } vec_t;

  vec_t tab[$];
  int total = 0;
  int bad = 0;

  function automatic logic [9:0] obs();
    return {ir_we, pc_we, reg_we, alu_src, mem_req, mem_wr, link, halt, pc_src};
  endfunction

  task automatic add(input logic r, input logic [2:0] op, input logic [3:0] fn,
                     input logic br, input logic mr, input logic [2:0] st,
                     input logic [9:0] o);
    vec_t v;
    v.r = r; v.op = op; v.fn = fn; v.br = br; v.mr = mr; v.st = st; v.o = o;
    tab.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive just after the rising edge, settle to the
  // falling edge where outputs are sampled.
  task automatic step(input logic r, input logic [2:0] op, input logic [3:0] fn,
                      input logic br, input logic mr);
    @(posedge clk);
    #1;
    rst = r; opcode = op; func = fn; br_cond = br; mem_ready = mr;
    @(negedge clk);
  endtask

`ifdef CTRL_PERF_CNT_EN
  int exp_ret = 0;
  int exp_stall = 0;
`endif

  initial begin
    // reset
    add(1,0,0,0,1, 0,O_Z);  add(1,0,0,0,1, 0,O_Z);
    // reg ALU: 0,1,2,4
    add(0,0,0,0,1, 0,O_FR); add(0,0,0,0,1, 1,O_Z);
    add(0,0,0,0,1, 2,O_Z);  add(0,0,0,0,1, 4,O_WB);
    // imm ALU; mem_ready low outside FETCH/MEM is ignored
    add(0,1,4'hf,0,1, 0,O_FR); add(0,1,0,0,0, 1,O_Z);
    add(0,1,0,0,0, 2,O_IMM);   add(0,1,0,0,0, 4,O_WB);
    // load, opcode changes after DECODE, 3 MEM stalls
    add(0,2,4'he,0,1, 0,O_FR); add(0,2,4'he,0,1, 1,O_Z);
    add(0,0,0,0,1, 2,O_IMM);
    add(0,0,0,0,0, 3,O_MLD);   add(0,0,0,0,0, 3,O_MLD);
    add(0,0,0,0,0, 3,O_MLD);   add(0,0,0,0,1, 3,O_MLD);
    add(0,0,0,0,1, 4,O_WB);
    // store, mem_ready high: 4 cycles
    add(0,2,1,0,1, 0,O_FR); add(0,2,1,0,1, 1,O_Z);
    add(0,2,1,0,1, 2,O_IMM); add(0,2,1,0,1, 3,O_MST);
    // FETCH stalls, then branch taken
    add(0,3,0,0,0, 0,O_F);  add(0,3,0,0,0, 0,O_F);
    add(0,3,0,0,1, 0,O_FR); add(0,3,0,0,1, 1,O_Z);
    add(0,3,0,1,1, 2,O_BR);
    // branch not taken (br_cond outside EXEC ignored)
    add(0,3,0,1,1, 0,O_FR); add(0,3,0,1,1, 1,O_Z);
    add(0,3,0,0,1, 2,O_Z);
    // jump
    add(0,4,0,0,1, 0,O_FR); add(0,4,0,0,1, 1,O_Z);
    add(0,4,0,0,1, 2,O_J);
    // call (func[1:0]=01) -> WB with link
    add(0,5,4'h5,0,1, 0,O_FR); add(0,5,4'h5,0,1, 1,O_Z);
    add(0,0,0,0,1, 2,O_J);     add(0,0,0,0,1, 4,O_WBL);
    // return (func[1:0]=11) -> back to FETCH
    add(0,5,4'h3,0,1, 0,O_FR); add(0,5,4'h3,0,1, 1,O_Z);
    add(0,5,4'h3,0,1, 2,O_J);
    // opcode 110 halts
    add(0,6,0,0,1, 0,O_FR); add(0,6,0,0,1, 1,O_Z);
    add(0,6,0,0,1, 5,O_H);  add(0,0,0,1,1, 5,O_H);
    // reset out of HALT, first FETCH requests memory
    add(1,0,0,0,1, 0,O_Z);  add(0,0,0,0,0, 0,O_F);
    add(0,0,0,0,1, 0,O_FR);

    for (int i = 0; i < tab.size(); i++) begin
      step(tab[i].r, tab[i].op, tab[i].fn, tab[i].br, tab[i].mr);
      check($sformatf("vec%0d state", i), {29'd0, state}, {29'd0, tab[i].st});
      check($sformatf("vec%0d strobes", i), {22'd0, obs()}, {22'd0, tab[i].o});
`ifdef CTRL_PERF_CNT_EN
      if (tab[i].r) begin exp_ret = 0; exp_stall = 0; end
      check($sformatf("vec%0d retired", i), retired, exp_ret);
      check($sformatf("vec%0d stall_cyc", i), stall_cyc, exp_stall);
      if (!tab[i].r) begin
        if ((tab[i].st == 0 || tab[i].st == 3) && !tab[i].mr) exp_stall++;
        if ((tab[i].st >= 2 && tab[i].st <= 4) && (i + 1 < tab.size()) &&
            tab[i+1].st == 0)
          exp_ret++;
      end
`endif
    end

    // opcode 111 -> HALT held for 20 cycles, then async reset
    step(1,0,0,0,1);
    check("halt7 reset state", {29'd0, state}, 32'd0);
    step(0,7,0,0,1);
    check("halt7 fetch", {22'd0, obs()}, {22'd0, O_FR});
    step(0,7,0,0,1);
    check("halt7 decode", {29'd0, state}, 32'd1);
    for (int k = 0; k < 20; k++) begin
      step(0,0,0,k[0],1);
      check($sformatf("halt7 c%0d state", k), {29'd0, state}, 32'd5);
      check($sformatf("halt7 c%0d strobes", k), {22'd0, obs()}, {22'd0, O_H});
    end
    #2 rst = 1'b1;
    #1;
    check("halt7 async rst state", {29'd0, state}, 32'd0);
    check("halt7 async rst halt", {31'd0, halt}, 32'd0);
    step(0,0,0,0,0);
    check("halt7 first fetch", {22'd0, obs()}, {22'd0, O_F});

    // store aborted by reset during MEM wait
    step(0,2,1,0,1);
    check("st fetch", {22'd0, obs()}, {22'd0, O_FR});
    step(0,2,1,0,1);
    step(0,2,1,0,0);
    check("st exec", {22'd0, obs()}, {22'd0, O_IMM});
    step(0,2,1,0,0);
    check("st mem wait1", {22'd0, obs()}, {22'd0, O_MST});
    step(0,2,1,0,0);
    check("st mem wait2 state", {29'd0, state}, 32'd3);
    #2 rst = 1'b1;
    #1;
    check("st async rst state", {29'd0, state}, 32'd0);
    check("st async rst strobes", {22'd0, obs()}, {22'd0, O_Z});
`ifdef CTRL_PERF_CNT_EN
    check("st async rst retired", retired, 32'd0);
`endif
    step(1,2,1,0,1);
    check("st rst held", {22'd0, obs()}, {22'd0, O_Z});
    step(0,0,0,0,0);
    check("st post-rst fetch", {22'd0, obs()}, {22'd0, O_F});
    step(0,0,0,0,1);
    check("st post-rst fetch rdy", {22'd0, obs()}, {22'd0, O_FR});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net against a stuck simulation.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ctrl_fsm.md
CTRL_FSM -- requirements
Module: ctrl_fsm

Interface
REQ-001 SHALL expose ports: clk  in  1  system clock, all state changes on rising edge.
REQ-002 SHALL expose: rst  in  1  asynchronous active-high reset.
REQ-003 SHALL expose: opcode  in  3  decoded opcode, valid in DECODE only.
REQ-004 SHALL expose: func  in  4  decoded function field, valid in DECODE only.
REQ-005 SHALL expose: br_cond  in  1  branch condition from flag unit, sampled in EXEC.
REQ-006 SHALL expose: mem_ready  in  1  memory completes current request this cycle.
REQ-007 SHALL expose outputs, all 1 bit: ir_we (latch instruction), pc_we (PC update), reg_we (register write), alu_src (0 reg / 1 imm), mem_req, mem_wr, link (write PC+1 to r31), halt.
REQ-008 SHALL expose outputs: pc_src  out  2  (00 PC+1, 01 branch target, 10 jump target); state  out  3  current state.
REQ-009 SHALL be single clock; rst asynchronous and active-high.

Function
REQ-010 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5; outputs Moore-decoded from state and latched opcode/func.
REQ-011 FETCH: mem_req=1, mem_wr=0; on mem_ready assert ir_we and pc_we (pc_src=00) in that cycle, go to DECODE; else stay.
REQ-012 DECODE: latch opcode and func into internal registers; opcode 110/111 -> HALT, else -> EXEC.
REQ-013 EXEC, opcode 000 (reg ALU): alu_src=0, -> WB.
REQ-014 EXEC, opcode 001 (imm ALU): alu_src=1, -> WB.
REQ-015 EXEC, opcode 010 (load/store, func[0]=1 store): alu_src=1, -> MEM.
REQ-016 EXEC, opcode 011 (branch): pc_we=br_cond, pc_src=01, -> FETCH.
REQ-017 EXEC, opcode 100 (jump): pc_we=1, pc_src=10, -> FETCH.
REQ-018 EXEC, opcode 101: func[1:0]==01 (call) -> pc_we=1, pc_src=10, -> WB with link; other func -> pc_we=1, pc_src=10, -> FETCH.
REQ-019 MEM: mem_req=1, mem_wr=func[0]; stay until mem_ready; then load -> WB, store -> FETCH.
REQ-020 WB: reg_we=1 exactly one cycle; link=1 only for call; -> FETCH.
REQ-021 Minimum latencies with mem_ready tied high: ALU/imm/call 4 cycles, load 5, store 4, branch/jump/return 3.
REQ-022 mem_req SHALL hold high and mem_wr stable until the mem_ready cycle; mem_ready outside FETCH/MEM ignored.
REQ-023 HALT: all strobes 0, halt=1, stays until rst.
REQ-024 No output strobe SHALL be asserted in any state other than listed; pc_src=00 when pc_we=0.

Reset
REQ-025 rst SHALL force state=FETCH immediately, latched opcode/func=0, all strobes and halt=0, pc_src=00.
REQ-026 rst mid-instruction (incl. MEM wait) SHALL abort it with no reg_we/pc_we issued.
REQ-027 After rst deasserts, mem_req asserts in the first FETCH cycle.

Configuration
REQ-028 Macro CTRL_PERF_CNT_EN SHALL add outputs retired[31:0] and stall_cyc[31:0].
REQ-029 With it: retired increments on each transition into FETCH from EXEC/MEM/WB; stall_cyc increments each FETCH/MEM cycle with mem_ready=0; both wrap modulo 2^32, reset to 0.
REQ-030 Without it: ports and counters absent; all other behaviour identical.

Verification
REQ-031 mem_ready=1, opcode 000 -> states 0,1,2,4,0; reg_we high one cycle in WB, alu_src=0.
REQ-032 load (010, func[0]=0), mem_ready low 3 cycles in MEM -> mem_req held 4 cycles, mem_wr=0, then WB reg_we=1; stall_cyc +3.
REQ-033 branch 011, br_cond=1 then br_cond=0 -> pc_we=1 pc_src=01 in first EXEC; pc_we=0 in second.
REQ-034 opcode 101 func=01 -> EXEC pc_we=1 pc_src=10, WB reg_we=1 link=1; func=00 -> no WB.
REQ-035 opcode 111 -> HALT, halt=1 for 20 cycles; rst -> FETCH, halt=0.
REQ-036 rst asserted during MEM wait of store -> state=FETCH asynchronously, mem_wr=0, no reg_we; retired unchanged.
